// File: rtl/ast_arb_pkg.sv
// Shared types and the round-robin selection function for the packet arbiter.
package ast_arb_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic [0:0] {
        IDLE_S = 1'b0,
        BUSY_S = 1'b1
    } arb_state_t;

    // Returns {valid, index}: first set request at or after ptr, wrapping modulo n.
    function automatic logic [3:0] rr_pick(input logic [MAX_SRC-1:0] req,
                                           input logic [2:0] ptr,
                                           input int n);
        logic [3:0] res;
        int idx;
        res = '0;
        for (int k = MAX_SRC - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (int'(ptr) + k) % n;
                if (req[idx[2:0]]) begin
                    res = {1'b1, idx[2:0]};
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST packet stream bundle with source and sink views.
interface avalon_st_if #(
    parameter int DATA_WIDTH    = 64,
    parameter int EMPTY_WIDTH   = 3,
    parameter int CHANNEL_WIDTH = 1
);
    logic [DATA_WIDTH-1:0]    data;
    logic                     valid;
    logic                     ready;
    logic                     startofpacket;
    logic                     endofpacket;
    logic [EMPTY_WIDTH-1:0]   empty;
    logic [CHANNEL_WIDTH-1:0] channel;

    modport src  (output data, valid, startofpacket, endofpacket, empty, channel, input ready);
    modport sink (input data, valid, startofpacket, endofpacket, empty, channel, output ready);
endinterface

// File: rtl/ast_packet_arbiter_rr_picker.sv
// Combinational round-robin picker; zero latency, no flow control of its own.
module rr_picker
    import ast_arb_pkg::*;
#(
    parameter int SRC_NUM = 2,
    parameter int PTR_W   = $clog2(SRC_NUM)
)(
    input  logic [SRC_NUM-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   grant,
    output logic               grant_valid
);

    logic [MAX_SRC-1:0] req_ext;
    logic [2:0]         ptr_ext;
    logic [3:0]         pick;

    always_comb begin
        req_ext              = '0;
        req_ext[SRC_NUM-1:0] = req;
        ptr_ext              = '0;
        ptr_ext[PTR_W-1:0]   = ptr;
        pick                 = rr_pick(req_ext, ptr_ext, SRC_NUM);
    end

    assign grant       = PTR_W'(pick[2:0]);
    assign grant_valid = pick[3];

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-level round-robin merge of SRC_NUM Avalon-ST inputs; 1-cycle arbitration,
// then zero-latency pass-through with same-cycle backpressure to the owning input.
module ast_packet_arbiter
    import ast_arb_pkg::*;
#(
    parameter int AST_DWIDTH    = 64,
    parameter int CHANNEL_WIDTH = 1,
    parameter int SRC_NUM       = 2,
    parameter int CNT_WIDTH     = 16
)(
    input  logic                               clk_i,
    input  logic                               srst_i,
    avalon_st_if.sink                          sink_if [SRC_NUM],
    avalon_st_if.src                           src_if,
    output logic [SRC_NUM-1:0][CNT_WIDTH-1:0]  pkt_cnt_o,
    output logic [SRC_NUM-1:0][CNT_WIDTH-1:0]  err_cnt_o
);

    localparam int PTR_W   = $clog2(SRC_NUM);
    localparam int EMPTY_W = $clog2(AST_DWIDTH / 8);

    if (CHANNEL_WIDTH < PTR_W) begin : g_bad_channel_width
        $error("CHANNEL_WIDTH is too narrow to carry the input index");
    end

    arb_state_t         state;
    logic [PTR_W-1:0]   grant;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   pick;
    logic               pick_vld;
    logic               eop_acc;

    logic [SRC_NUM-1:0]    in_vld;
    logic [SRC_NUM-1:0]    in_sop;
    logic [SRC_NUM-1:0]    in_eop;
    logic [SRC_NUM-1:0]    in_rdy;
    logic [AST_DWIDTH-1:0] in_dat   [SRC_NUM];
    logic [EMPTY_W-1:0]    in_empty [SRC_NUM];

    logic                     out_vld;
    logic                     out_sop;
    logic                     out_eop;
    logic [AST_DWIDTH-1:0]    out_dat;
    logic [EMPTY_W-1:0]       out_empty;
    logic [CHANNEL_WIDTH-1:0] out_ch;

    rr_picker #(
        .SRC_NUM (SRC_NUM),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req         ((state == IDLE_S) ? (in_vld & in_sop) : '0),
        .ptr         (rr_ptr),
        .grant       (pick),
        .grant_valid (pick_vld)
    );

    // Idle cycles drain stray mid-packet beats; busy cycles hand the output to the owner.
    always_comb begin
        in_rdy    = '0;
        out_vld   = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_dat   = '0;
        out_empty = '0;
        out_ch    = '0;
        if (state == BUSY_S) begin
            out_vld       = in_vld[grant];
            out_sop       = in_sop[grant];
            out_eop       = in_eop[grant];
            out_dat       = in_dat[grant];
            out_empty     = in_empty[grant];
            out_ch        = CHANNEL_WIDTH'(grant);
            in_rdy[grant] = src_if.ready;
        end else begin
            in_rdy = in_vld & ~in_sop;
        end
    end

    assign eop_acc              = out_vld & src_if.ready & out_eop;
    assign src_if.valid         = out_vld;
    assign src_if.startofpacket = out_sop;
    assign src_if.endofpacket   = out_eop;
    assign src_if.data          = out_dat;
    assign src_if.empty         = out_empty;
    assign src_if.channel       = out_ch;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state  <= IDLE_S;
            grant  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                IDLE_S: begin
                    if (pick_vld) begin
                        grant <= pick;
                        state <= BUSY_S;
                    end
                end
                BUSY_S: begin
                    if (eop_acc) begin
                        rr_ptr <= (grant == PTR_W'(SRC_NUM - 1)) ? '0 : grant + 1'b1;
                        state  <= IDLE_S;
                    end
                end
                default: state <= IDLE_S;
            endcase
        end
    end

    for (genvar i = 0; i < SRC_NUM; i++) begin : g_in
        logic [CNT_WIDTH-1:0] pkt_cnt;
        logic [CNT_WIDTH-1:0] err_cnt;

        assign in_vld[i]        = sink_if[i].valid;
        assign in_sop[i]        = sink_if[i].startofpacket;
        assign in_eop[i]        = sink_if[i].endofpacket;
        assign in_dat[i]        = sink_if[i].data;
        assign in_empty[i]      = sink_if[i].empty;
        assign sink_if[i].ready = in_rdy[i];

        always_ff @(posedge clk_i) begin
            if (srst_i) begin
                pkt_cnt <= '0;
                err_cnt <= '0;
            end else begin
                if (eop_acc && (grant == PTR_W'(i))) begin
                    pkt_cnt <= pkt_cnt + 1'b1;
                end
                if ((state == IDLE_S) && in_vld[i] && !in_sop[i]) begin
                    err_cnt <= err_cnt + 1'b1;
                end
            end
        end

        assign pkt_cnt_o[i] = pkt_cnt;
        assign err_cnt_o[i] = err_cnt;
    end

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Scoreboard bench for ast_packet_arbiter with four inputs and a two-bit channel.
module tb_ast_packet_arbiter;

    localparam int DW   = 64;
    localparam int EW   = 3;
    localparam int CW   = 2;
    localparam int NS   = 4;
    localparam int CNTW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [CW-1:0] ch;
        logic          sop;
        logic          eop;
        logic [EW-1:0] empty;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                      srst;
    logic                      src_rdy;
    logic [NS-1:0]             tb_vld;
    logic [NS-1:0]             tb_sop;
    logic [NS-1:0]             tb_eop;
    logic [NS-1:0]             tb_rdy;
    logic [DW-1:0]             tb_dat [NS];
    logic [EW-1:0]             tb_emp [NS];
    logic [NS-1:0][CNTW-1:0]   pkt_cnt;
    logic [NS-1:0][CNTW-1:0]   err_cnt;

    avalon_st_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(1))  sink_if [NS] ();
    avalon_st_if #(.DATA_WIDTH(DW), .EMPTY_WIDTH(EW), .CHANNEL_WIDTH(CW)) src_if ();

    for (genvar g = 0; g < NS; g++) begin : g_drv
        assign sink_if[g].valid         = tb_vld[g];
        assign sink_if[g].startofpacket = tb_sop[g];
        assign sink_if[g].endofpacket   = tb_eop[g];
        assign sink_if[g].data          = tb_dat[g];
        assign sink_if[g].empty         = tb_emp[g];
        assign sink_if[g].channel       = 1'b0;
        assign tb_rdy[g]                = sink_if[g].ready;
    end
    assign src_if.ready = src_rdy;

    ast_packet_arbiter #(
        .AST_DWIDTH    (DW),
        .CHANNEL_WIDTH (CW),
        .SRC_NUM       (NS),
        .CNT_WIDTH     (CNTW)
    ) dut (
        .clk_i     (clk),
        .srst_i    (srst),
        .sink_if   (sink_if),
        .src_if    (src_if),
        .pkt_cnt_o (pkt_cnt),
        .err_cnt_o (err_cnt)
    );

    beat_t         drv_q [NS][$];
    beat_t         sb_q [$];
    int            gap_q [$];
    int            eop_cyc [NS];
    int            cyc        = 0;
    int            out_cnt    = 0;
    int            last_eop   = -1;
    int            first_rdy1 = -1;
    int            n_checks   = 0;
    int            n_pass     = 0;
    logic [NS-1:0] fired      = '0;
    beat_t         got;
    beat_t         exp_b;

    // Output monitor: compares every accepted output beat against the scoreboard.
    always @(negedge clk) begin
        cyc++;
        fired = tb_vld & tb_rdy;
        if (tb_rdy[1] && first_rdy1 < 0) first_rdy1 = cyc;
        if (src_if.valid && src_rdy) begin
            got = {src_if.data, src_if.channel, src_if.startofpacket,
                   src_if.endofpacket, src_if.empty};
            out_cnt++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_beat: got %h, required no beat", got);
            end else begin
                exp_b = sb_q.pop_front();
                if (got !== exp_b) $display("FAIL out_beat: got %h, required %h", got, exp_b);
                else n_pass++;
            end
            if (got.sop && last_eop >= 0) gap_q.push_back(cyc - last_eop);
            if (got.eop) begin
                last_eop     = cyc;
                eop_cyc[got.ch] = cyc;
            end
        end
    end

    // Input drivers: each input streams its queue, advancing on an accepted beat.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < NS; i++) begin
            if (fired[i] && drv_q[i].size() > 0) void'(drv_q[i].pop_front());
            if (drv_q[i].size() > 0) begin
                tb_vld[i] = 1'b1;
                tb_sop[i] = drv_q[i][0].sop;
                tb_eop[i] = drv_q[i][0].eop;
                tb_dat[i] = drv_q[i][0].data;
                tb_emp[i] = drv_q[i][0].empty;
            end else begin
                tb_vld[i] = 1'b0;
                tb_sop[i] = 1'b0;
                tb_eop[i] = 1'b0;
            end
        end
    end

    task automatic push_pkt(input int src, input int nbeats, input int tag,
                            input int nexp, input bit with_sop);
        beat_t bt;
        for (int b = 0; b < nbeats; b++) begin
            bt.data  = {16'hC0DE, 8'(src), 8'(tag), 24'h0, 8'(b)};
            bt.ch    = CW'(src);
            bt.sop   = with_sop && (b == 0);
            bt.eop   = with_sop && (b == nbeats - 1);
            bt.empty = bt.eop ? 3'd5 : 3'd0;
            drv_q[src].push_back(bt);
            if (b < nexp) sb_q.push_back(bt);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 srst = 1'b1;
        repeat (2) @(posedge clk);
        #1 srst = 1'b0;
        last_eop   = -1;
        first_rdy1 = -1;
        gap_q.delete();
    endtask

    task automatic wait_drain(input string name);
        int t;
        bit busy;
        t = 0;
        do begin
            @(posedge clk); #2;
            busy = (sb_q.size() != 0);
            for (int i = 0; i < NS; i++) if (drv_q[i].size() != 0) busy = 1'b1;
            t++;
        end while (busy && t < 2000);
        n_checks++;
        if (busy) $display("FAIL %s_drain: %0d beats outstanding after timeout, required 0", name, sb_q.size());
        else n_pass++;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (src_if.valid !== 1'b0) $display("FAIL reset_valid: got %b, required 0", src_if.valid);
        else n_pass++;
        n_checks++;
        if (src_if.channel !== 2'd0) $display("FAIL reset_channel: got %0d, required 0", src_if.channel);
        else n_pass++;
        n_checks++;
        if (tb_rdy !== 4'b0) $display("FAIL reset_ready: got %b, required 0000", tb_rdy);
        else n_pass++;
        n_checks++;
        if (pkt_cnt !== '0) $display("FAIL reset_pkt_cnt: got %h, required 0", pkt_cnt);
        else n_pass++;
        n_checks++;
        if (err_cnt !== '0) $display("FAIL reset_err_cnt: got %h, required 0", err_cnt);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        do_reset();
        push_pkt(0, 3, 1, 3, 1'b1);
        push_pkt(1, 3, 2, 3, 1'b1);
        push_pkt(0, 3, 3, 3, 1'b1);
        push_pkt(1, 3, 4, 3, 1'b1);
        wait_drain("rr");
        n_checks++;
        if (pkt_cnt[0] !== 16'd2) $display("FAIL rr_pkt_cnt0: got %0d, required 2", pkt_cnt[0]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[1] !== 16'd2) $display("FAIL rr_pkt_cnt1: got %0d, required 2", pkt_cnt[1]);
        else n_pass++;
        n_checks++;
        if (gap_q.size() != 3) $display("FAIL rr_gap_count: got %0d, required 3", gap_q.size());
        else n_pass++;
        foreach (gap_q[k]) begin
            n_checks++;
            if (gap_q[k] != 2) $display("FAIL rr_gap%0d: got %0d cycles, required 2", k, gap_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_single_beat();
        do_reset();
        for (int k = 0; k < 5; k++) push_pkt(1, 1, 16 + k, 1, 1'b1);
        wait_drain("single");
        n_checks++;
        if (pkt_cnt[1] !== 16'd5) $display("FAIL single_pkt_cnt1: got %0d, required 5", pkt_cnt[1]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[0] !== 16'd0) $display("FAIL single_pkt_cnt0: got %0d, required 0", pkt_cnt[0]);
        else n_pass++;
        n_checks++;
        if (gap_q.size() != 4) $display("FAIL single_gap_count: got %0d, required 4", gap_q.size());
        else n_pass++;
        foreach (gap_q[k]) begin
            n_checks++;
            if (gap_q[k] != 2) $display("FAIL single_gap%0d: got %0d cycles, required 2", k, gap_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int t;
        bit busy;
        do_reset();
        push_pkt(0, 8, 32, 8, 1'b1);
        push_pkt(1, 2, 33, 2, 1'b1);
        t    = 0;
        busy = 1'b1;
        while (busy && t < 400) begin
            @(posedge clk); #1;
            src_rdy = ~src_rdy;
            busy    = (drv_q[0].size() != 0) || (drv_q[1].size() != 0);
            t++;
        end
        src_rdy = 1'b1;
        wait_drain("bp");
        n_checks++;
        if (first_rdy1 != eop_cyc[0] + 2)
            $display("FAIL bp_in1_holdoff: first in1 ready at cycle %0d, required %0d", first_rdy1, eop_cyc[0] + 2);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[0] !== 16'd1 || pkt_cnt[1] !== 16'd1)
            $display("FAIL bp_pkt_cnt: got %0d/%0d, required 1/1", pkt_cnt[0], pkt_cnt[1]);
        else n_pass++;
    endtask

    task automatic test_discard();
        do_reset();
        push_pkt(0, 2, 48, 0, 1'b0);
        push_pkt(0, 3, 49, 3, 1'b1);
        wait_drain("discard");
        n_checks++;
        if (err_cnt[0] !== 16'd2) $display("FAIL discard_err_cnt0: got %0d, required 2", err_cnt[0]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[0] !== 16'd1) $display("FAIL discard_pkt_cnt0: got %0d, required 1", pkt_cnt[0]);
        else n_pass++;
        n_checks++;
        if (err_cnt[1] !== 16'd0) $display("FAIL discard_err_cnt1: got %0d, required 0", err_cnt[1]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_packet();
        int base;
        int t;
        do_reset();
        base = out_cnt;
        push_pkt(1, 6, 64, 3, 1'b1);
        t = 0;
        while (out_cnt < base + 2 && t < 200) begin
            @(posedge clk);
            t++;
        end
        n_checks++;
        if (out_cnt < base + 2) $display("FAIL rst_mid_wait: got %0d beats, required 2", out_cnt - base);
        else n_pass++;
        #1 srst = 1'b1;
        @(posedge clk);
        #1 srst = 1'b0;
        n_checks++;
        if (src_if.valid !== 1'b0) $display("FAIL rst_mid_valid: got %b, required 0", src_if.valid);
        else n_pass++;
        n_checks++;
        if (pkt_cnt !== '0 || err_cnt !== '0)
            $display("FAIL rst_mid_counters: got pkt %h err %h, required 0", pkt_cnt, err_cnt);
        else n_pass++;
        wait_drain("rst_mid");
        n_checks++;
        if (err_cnt[1] !== 16'd3) $display("FAIL rst_mid_err_cnt1: got %0d, required 3", err_cnt[1]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[1] !== 16'd0) $display("FAIL rst_mid_pkt_cnt1: got %0d, required 0", pkt_cnt[1]);
        else n_pass++;
    endtask

    task automatic test_rr_ptr2();
        do_reset();
        push_pkt(1, 1, 80, 1, 1'b1);
        wait_drain("ptr2_setup");
        push_pkt(3, 1, 81, 1, 1'b1);
        push_pkt(1, 1, 82, 1, 1'b1);
        wait_drain("ptr2");
        n_checks++;
        if (!(eop_cyc[3] < eop_cyc[1]))
            $display("FAIL ptr2_order: in3 done at %0d, in1 done at %0d, required in3 first", eop_cyc[3], eop_cyc[1]);
        else n_pass++;
        n_checks++;
        if (pkt_cnt[1] !== 16'd2 || pkt_cnt[3] !== 16'd1)
            $display("FAIL ptr2_pkt_cnt: got in1=%0d in3=%0d, required 2/1", pkt_cnt[1], pkt_cnt[3]);
        else n_pass++;
    endtask

    initial begin
        srst    = 1'b1;
        src_rdy = 1'b1;
        tb_vld  = '0;
        tb_sop  = '0;
        tb_eop  = '0;
        for (int i = 0; i < NS; i++) begin
            tb_dat[i]  = '0;
            tb_emp[i]  = '0;
            eop_cyc[i] = -1;
        end
        test_reset();
        test_round_robin();
        test_single_beat();
        test_backpressure();
        test_discard();
        test_reset_mid_packet();
        test_rr_ptr2();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
